// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: sample width, envelope width and
// ADSR state encodings used by the oscillator and envelope stages.
package synth_pkg;

  localparam int DATA_W = 31;
  localparam int ENV_W  = 16;

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_st_e;

endpackage

// File: rtl/adsr_env_core.sv
// ADSR envelope FSM with a saturating envelope register.
// Advances only on sample strobes.
module adsr_env_core
  import synth_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             gate_i,
  input  logic [ENV_W-1:0] atk_i,
  input  logic [ENV_W-1:0] dec_i,
  input  logic [ENV_W-1:0] sus_i,
  input  logic [ENV_W-1:0] rel_i,
  output logic [ENV_W-1:0] env_o,
  output env_st_e          state_o
);

  logic [ENV_W-1:0] env_q;
  env_st_e          state_q;
  logic             gate_q;

  logic [ENV_W:0]   sum_w;
  logic [ENV_W:0]   dec_w;
  logic [ENV_W:0]   rel_w;
  logic [ENV_W-1:0] atk_d;
  logic [ENV_W-1:0] dcy_d;
  logic [ENV_W-1:0] rel_d;
  logic             rise;

  // One extra bit catches overflow/borrow; a zero step jumps to target.
  always_comb begin
    sum_w = {1'b0, env_q} + {1'b0, atk_i};
    dec_w = {1'b0, env_q} - {1'b0, dec_i};
    rel_w = {1'b0, env_q} - {1'b0, rel_i};
    atk_d = sum_w[ENV_W-1:0];
    dcy_d = dec_w[ENV_W-1:0];
    rel_d = rel_w[ENV_W-1:0];
    if (atk_i == '0 || sum_w[ENV_W])
      atk_d = ENV_MAX;
    if (dec_i == '0 || dec_w[ENV_W] ||
        dec_w[ENV_W-1:0] < sus_i)
      dcy_d = sus_i;
    if (rel_i == '0 || rel_w[ENV_W])
      rel_d = '0;
  end

  assign rise = gate_i & ~gate_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      env_q   <= '0;
      state_q <= ST_IDLE;
      gate_q  <= 1'b0;
    end else if (ena_i) begin
      gate_q <= gate_i;
      if (rise) begin
        state_q <= ST_ATTACK;
      end else if (!gate_i &&
                   state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) begin
        state_q <= ST_RELEASE;
      end else begin
        unique case (state_q)
          ST_ATTACK: begin
            env_q <= atk_d;
            if (atk_d == ENV_MAX) state_q <= ST_DECAY;
          end
          ST_DECAY: begin
            env_q <= dcy_d;
            if (dcy_d == sus_i) state_q <= ST_SUSTAIN;
          end
          ST_SUSTAIN: env_q <= sus_i;
          ST_RELEASE: begin
            env_q <= rel_d;
            if (rel_d == '0) state_q <= ST_IDLE;
          end
          default: begin
            env_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign env_o   = env_q;
  assign state_o = state_q;

endmodule

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a two-stage signed VCA multiply.
// Output lags the sample strobe by two clocks.
module adsr_vca #(
  parameter int DATA_W = synth_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           gate,
  input  logic [synth_pkg::ENV_W-1:0]    attack_step,
  input  logic [synth_pkg::ENV_W-1:0]    decay_step,
  input  logic [synth_pkg::ENV_W-1:0]    sustain_level,
  input  logic [synth_pkg::ENV_W-1:0]    release_step,
  input  logic signed [DATA_W-1:0]       sample_in,
  output logic signed [DATA_W-1:0]       sample_out,
  output logic                           out_valid,
  output logic [synth_pkg::ENV_W-1:0]    env_out,
  output logic [2:0]                     env_state
);

  import synth_pkg::*;

  localparam int PW = DATA_W + ENV_W + 1;

  logic [ENV_W-1:0]         env;
  env_st_e                  st;

  logic signed [PW-1:0]     prod_d;
  logic signed [PW-1:0]     prod_q;
  logic signed [DATA_W-1:0] smp_q;
  logic signed [DATA_W-1:0] out_q;
  logic                     unity_q;
  logic                     v1_q;
  logic                     vld_q;
  logic                     unused_bits;

  adsr_env_core u_env (
    .clk_i   (clk),
    .rst_ni  (rst),
    .ena_i   (ena),
    .gate_i  (gate),
    .atk_i   (attack_step),
    .dec_i   (decay_step),
    .sus_i   (sustain_level),
    .rel_i   (release_step),
    .env_o   (env),
    .state_o (st)
  );

  // Envelope is treated as unsigned Q0.16 gain; pre-update value is used.
  assign prod_d = PW'(sample_in) * PW'($signed({1'b0, env}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      smp_q   <= '0;
      unity_q <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= ena;
      if (ena) begin
        prod_q  <= prod_d;
        smp_q   <= sample_in;
        unity_q <= (env == ENV_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= v1_q;
      if (v1_q)
        out_q <= unity_q ? smp_q : prod_q[ENV_W +: DATA_W];
    end
  end

  assign unused_bits = ^{prod_q[PW-1], prod_q[ENV_W-1:0]};

  assign sample_out = out_q;
  assign out_valid  = vld_q;
  assign env_out    = env;
  assign env_state  = st;

endmodule

// File: doc/adsr_vca.md
Name: adsr_vca

Overview:
- Downstream consumer of the sine oscillator stage: takes its signed 31-bit sample stream and applies an ADSR amplitude envelope.
- Produces a gated, shaped note sample for the synthesizer mix/output stages.
- Contains an envelope state machine that advances once per sample strobe and a 2-stage signed multiply (VCA) pipeline.

Parameters:
- DATA_W, 31, sample width, signed; matches oscillator output.
- ENV_W, 16, envelope magnitude width, unsigned; ENV_MAX = 2**ENV_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  sample strobe, one clk-wide pulse per sample, shared with the oscillator.
- gate  in  1  note on (1) / off (0); sampled only on ena cycles.
- attack_step  in  ENV_W  env increment per sample in ATTACK.
- decay_step  in  ENV_W  env decrement per sample in DECAY.
- sustain_level  in  ENV_W  SUSTAIN target.
- release_step  in  ENV_W  env decrement per sample in RELEASE.
- sample_in  in  DATA_W signed  oscillator sample, valid when ena=1.
- sample_out  out  DATA_W signed  enveloped sample.
- out_valid  out  1  sample_out updated this cycle.
- env_out  out  ENV_W  current envelope value.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Behaviour:
- Reset (rst=0, async, immediate):
  - sample_out=0, out_valid=0, env_out=0, env_state=IDLE.
  - gate_prev=0 and pipeline registers cleared.
  - Reset asserted mid-note aborts the note with no drain.
- State and env change only on clk edges with ena=1; with ena=0 they hold.
- gate_prev is updated only on ena cycles. Rise = gate=1 and gate_prev=0.
- Transitions (evaluated in priority order each ena cycle):
  - Rise, any state -> ATTACK. env keeps its current value (retrigger without reset; no click).
  - gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE, starting from the current env.
  - ATTACK: env = min(env+attack_step, ENV_MAX); env == ENV_MAX after the update -> DECAY.
  - DECAY: env = max(env-decay_step, sustain_level); env == sustain_level -> SUSTAIN.
  - SUSTAIN: env = sustain_level every ena cycle, so the level tracks live changes.
  - RELEASE: env = max(env-release_step, 0); env == 0 -> IDLE.
  - IDLE: env = 0.
- Step = 0 means instantaneous: env jumps to that phase's target in one ena cycle (attack to ENV_MAX, decay to sustain_level, release to 0).
- Saturation arithmetic uses ENV_W+1 bits internally. No wrap-around ever.
- sustain_level = ENV_MAX: DECAY exits to SUSTAIN on its first ena cycle.
- VCA stage 1, on ena=1:
  - Capture sample_in and the env value from before this cycle's update.
  - prod = sample_in * signed({1'b0, env}) as a DATA_W+ENV_W+1 bit product.
  - v1 <= 1.
- VCA stage 2, on v1=1:
  - sample_out = prod >>> ENV_W (arithmetic shift, floor), truncated to DATA_W.
  - When the captured env == ENV_MAX, sample_out = sample_in exactly (unity bypass).
- Latency: ena at cycle n -> out_valid=1 and new sample_out at cycle n+2. out_valid is a 1-cycle pulse.
- sample_out holds between updates.
- Back-to-back ena (every clock) is supported at full throughput.

Decomposition:
- Shared package synth_pkg holds:
  - state encodings ST_IDLE..ST_RELEASE;
  - ENV_W and ENV_MAX;
  - the DATA_W default (31), shared with the oscillator.
- One sub-module, adsr_env_core: FSM plus saturating env register, with outputs env and state.
- The VCA multiply pipeline stays in adsr_vca.

Test Plan:
1. Reset then idle: rst=0, release, ena every cycle, sample_in=1000, gate=0 -> env_out=0, sample_out=0, out_valid pulses at n+2.
2. Attack/decay/sustain: attack_step=16384, decay_step=8192, sustain_level=32768, gate=1 -> env 16384, 32768, 49152, 65535 (ATTACK->DECAY), 57343, 49151, 40959, 32768 (SUSTAIN). sample_in=2^29 with env 32768 -> sample_out=2^28.
3. Unity and sign: env=ENV_MAX, sample_in=-5 -> sample_out=-5. env=32768, sample_in=-3 -> sample_out=-2 (floor).
4. Release and retrigger: in SUSTAIN at 32768, release_step=10000, gate=0 -> 22768, 12768, 2768, 0, IDLE. Gate rise at env=12768 -> ATTACK continuing from 12768.
5. Zero steps and ena gaps: all steps=0, gate=1 -> ENV_MAX then sustain_level in consecutive ena cycles. ena low 5 cycles mid-attack -> env and state frozen.
6. Async reset mid-DECAY between clock edges -> all outputs 0 and IDLE immediately, before the next clk edge.
